spwm_phase_seq: RTL and testbench

- Upstream sequencer for the sine-PWM generator.
- Walks the 6-bit sine-table index through one half-sine per polarity, stepping only on PWM frame boundaries so duty changes never glitch mid-frame.
- Emits a half-cycle polarity flag that drives H-bridge leg selection.
- Frame length matches the downstream PWM period of 101 clocks.
- Step rate is programmable in whole frames per index step.

---
 rtl/spwm_phase_seq.sv | 142 ++++++++++++++
 tb/tb_spwm_phase_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spwm_phase_seq.sv
// spwm_phase_seq
// Upstream sequencer for the sine-PWM generator. Walks the sine-table index
// 0..SEL_LAST through one half-sine per polarity. The index only moves on PWM
// frame boundaries, so the downstream duty value never changes mid-frame.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   start       1-cycle pulse, begins sequencing when idle
//   stop        1-cycle pulse, graceful stop at the next half-cycle boundary
//   oneshot     sampled with start; run one full cycle (both halves) then stop
//   step_div    frames per index step minus 1
//   sel1        sine-table index to the PWM stage
//   polarity    0 = positive half, 1 = negative half
//   frame_tick  1-cycle pulse on the last clock of each frame
//   half_done   1-cycle pulse when the index wraps SEL_LAST -> 0
//   cycle_done  1-cycle pulse when the negative half completes
//   busy        high in RUN or STOPPING
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | counters held at 0, sel1 = 0, polarity = 0
// S_RUN      | normal sequencing
// S_STOPPING | sequencing continues until the next half-cycle boundary

module spwm_phase_seq #(
  parameter int FRAME_LEN = 101,
  parameter int SEL_LAST  = 35,
  parameter int DIV_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [DIV_W-1:0] step_div,
  output logic [5:0]       sel1,
  output logic             polarity,
  output logic             frame_tick,
  output logic             half_done,
  output logic             cycle_done,
  output logic             busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;

  localparam logic [6:0] FCNT_LAST = 7'(FRAME_LEN - 1);
  localparam logic [6:0] FCNT_PRE  = 7'(FRAME_LEN - 2);
  localparam logic [5:0] SEL_MAX   = 6'(SEL_LAST);

  logic [1:0]       state;
  logic [6:0]       fcnt;
  logic [DIV_W-1:0] dcnt;
  logic [DIV_W-1:0] div_q;
  logic             os_q;

  logic step_now;
  logic wrap_now;
  logic end_now;

  // frame_tick is itself the registered "fcnt == last" decode, so the step
  // decision is taken on the edge that closes the frame.
  always_comb begin
    step_now = 1'b0;
    wrap_now = 1'b0;
    end_now  = 1'b0;
    if (state != S_IDLE) begin
      step_now = frame_tick && (dcnt == div_q);
      wrap_now = step_now && (sel1 == SEL_MAX);
      end_now  = wrap_now && ((state == S_STOPPING) || (polarity && os_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      fcnt       <= '0;
      dcnt       <= '0;
      div_q      <= '0;
      os_q       <= 1'b0;
      sel1       <= '0;
      polarity   <= 1'b0;
      frame_tick <= 1'b0;
      half_done  <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      half_done  <= 1'b0;
      cycle_done <= 1'b0;
      case (state)
        S_IDLE: begin
          fcnt     <= '0;
          dcnt     <= '0;
          sel1     <= '0;
          polarity <= 1'b0;
          if (start && !stop) begin
            state <= S_RUN;
            div_q <= step_div;
            os_q  <= oneshot;
          end
        end
        S_RUN, S_STOPPING: begin
          fcnt       <= (fcnt == FCNT_LAST) ? '0 : fcnt + 7'd1;
          frame_tick <= (fcnt == FCNT_PRE);
          if ((state == S_RUN) && stop)
            state <= S_STOPPING;
          if (frame_tick) begin
            if (step_now) begin
              dcnt  <= '0;
              // A new divisor only applies from the following step.
              div_q <= step_div;
              if (wrap_now) begin
                sel1       <= '0;
                polarity   <= ~polarity;
                half_done  <= 1'b1;
                cycle_done <= polarity;
              end else begin
                sel1 <= sel1 + 6'd1;
              end
            end else begin
              dcnt <= dcnt + DIV_W'(1);
            end
          end
          // Leaving on a half boundary: sel1 already wraps to 0 above,
          // polarity is forced back to the positive half.
          if (end_now) begin
            state    <= S_IDLE;
            fcnt     <= '0;
            dcnt     <= '0;
            polarity <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spwm_phase_seq.sv
module tb_spwm_phase_seq;

  logic       clk = 1'b0;
  logic       rst, start, stop, oneshot;
  logic [7:0] step_div;
  logic [5:0] sel1;
  logic       polarity, frame_tick, half_done, cycle_done, busy;

  always #5 clk = ~clk;

  spwm_phase_seq dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .step_div(step_div), .sel1(sel1), .polarity(polarity),
    .frame_tick(frame_tick), .half_done(half_done), .cycle_done(cycle_done),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: tracks clocks since start and total index steps taken;
  // sel1/polarity are derived arithmetically from the step total.
  bit m_busy = 0, m_os = 0, m_stopreq = 0, m_hd = 0, m_cd = 0, m_ft = 0;
  int m_t = 0, m_k = 0, m_frames = 0, m_due = 0;

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      if (failures >= 50) finish_now();
    end
  endtask

  task automatic model_update();
    bit fend, sreq_old;
    if (rst) begin
      m_busy = 0; m_hd = 0; m_cd = 0; m_ft = 0; m_k = 0;
      return;
    end
    m_hd = 0; m_cd = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_t = 0; m_k = 0; m_frames = 0;
        m_due = int'(step_div) + 1; m_os = oneshot; m_stopreq = 0;
      end
    end else begin
      fend = (m_t % 101 == 100);
      sreq_old = m_stopreq;
      m_t++;
      if (fend) begin
        m_frames++;
        if (m_frames == m_due) begin
          m_k++;
          m_due = m_frames + int'(step_div) + 1;
          if (m_k % 36 == 0) begin
            m_hd = 1;
            m_cd = (m_k % 72 == 0);
            if (sreq_old || (m_os && m_cd)) m_busy = 0;
          end
        end
      end
      if (stop) m_stopreq = 1;
    end
    m_ft = m_busy && (m_t % 101 == 100);
  endtask

  task automatic tick();
    int e_sel, e_pol;
    @(posedge clk);
    model_update();
    #1;
    e_sel = m_busy ? (m_k % 36) : 0;
    e_pol = m_busy ? ((m_k / 36) % 2) : 0;
    check("model_busy", int'(busy), int'(m_busy));
    check("model_sel1", int'(sel1), e_sel);
    check("model_pol", int'(polarity), e_pol);
    check("model_pulses", int'({frame_tick, half_done, cycle_done}),
          int'({m_ft, m_hd, m_cd}));
  endtask

  typedef struct {
    bit       rst, start, stop, oneshot;
    bit [7:0] div;
    bit       e_busy;
    bit [5:0] e_sel;
    bit       e_pol;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, ft;
    rst = 1; start = 0; stop = 0; oneshot = 0; step_div = 0;

    tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 1, 2, 1, 0, 0};
    tbl[6] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
      oneshot = tbl[i].oneshot; step_div = tbl[i].div;
      tick();
      check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      check($sformatf("vec%0d_sel1", i), int'(sel1), int'(tbl[i].e_sel));
      check($sformatf("vec%0d_pol", i), int'(polarity), int'(tbl[i].e_pol));
    end
    rst = 0; start = 0; stop = 0; oneshot = 0; step_div = 0;

    // Free-running cycle, step every frame, start pulse ignored mid-frame.
    start = 1; tick(); start = 0;
    n = 0;
    do begin start = (n == 30); tick(); n++; end while (sel1 != 1 && n < 200);
    start = 0;
    check("s1_first_step", n, 101);
    do begin tick(); n++; end while (!polarity && n < 4000);
    check("s1_half_edge", n, 3636);
    check("s1_half_done", int'(half_done), 1);
    check("s1_half_sel", int'(sel1), 0);
    do begin tick(); n++; end while (!cycle_done && n < 8000);
    check("s1_cycle_edge", n, 7272);
    check("s1_cycle_pol", int'(polarity), 0);
    check("s1_cycle_busy", int'(busy), 1);
    rst = 1; tick(); rst = 0;

    // Divisor 3, changed to 1 during the second step.
    step_div = 3; start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (sel1 != 1 && n < 1000);
    check("s2_step1", n, 404);
    n = 0;
    do begin
      if (n == 150) step_div = 1;
      tick(); n++;
    end while (sel1 != 2 && n < 1000);
    check("s2_step2", n, 404);
    n = 0;
    do begin tick(); n++; end while (sel1 != 3 && n < 1000);
    check("s2_step3", n, 202);
    n = 0;
    do begin tick(); n++; end while (sel1 != 4 && n < 1000);
    check("s2_step4", n, 202);
    rst = 1; tick(); rst = 0; step_div = 0;

    // Oneshot: exactly one full cycle, then idle with no more frames.
    oneshot = 1; start = 1; tick(); start = 0; oneshot = 0;
    n = 0; ft = 0;
    do begin tick(); n++; if (frame_tick) ft++; end while (busy && n < 8000);
    check("os_end_edge", n, 7272);
    check("os_frame_ticks", ft, 72);
    check("os_cycle_done", int'(cycle_done), 1);
    check("os_half_done", int'(half_done), 1);
    check("os_sel", int'(sel1), 0);
    check("os_pol", int'(polarity), 0);
    ft = 0;
    for (int i = 0; i < 300; i++) begin tick(); if (frame_tick) ft++; end
    check("os_idle_ticks", ft, 0);

    // Graceful stop in the negative half.
    start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (!(sel1 == 10 && polarity) && n < 6000);
    check("stop_reach", n, 4646);
    stop = 1; tick(); stop = 0;
    n = 1;
    do begin tick(); n++; end while (busy && n < 4000);
    check("stop_end_edge", n, 2626);
    check("stop_half_done", int'(half_done), 1);
    check("stop_cycle_done", int'(cycle_done), 1);
    check("stop_sel", int'(sel1), 0);
    check("stop_pol", int'(polarity), 0);

    // Reset mid-run, then a clean restart.
    start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (sel1 != 20 && n < 3000);
    check("rst_reach", n, 2020);
    rst = 1; tick(); rst = 0;
    check("rst_busy", int'(busy), 0);
    check("rst_sel", int'(sel1), 0);
    check("rst_pulses", int'({frame_tick, half_done, cycle_done}), 0);
    start = 1; tick(); start = 0;
    n = 0;
    do begin tick(); n++; end while (sel1 != 1 && n < 200);
    check("rst_restart_step", n, 101);
    rst = 1; tick(); rst = 0;

    // Random pulses and divisors against the model.
    for (int i = 0; i < 20000; i++) begin
      start = ($urandom_range(0, 199) == 0);
      stop  = ($urandom_range(0, 2999) == 0);
      oneshot = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 499) == 0)
        step_div = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'd0;
      rst = ($urandom_range(0, 9999) == 0);
      tick();
    end
    rst = 0; start = 0; stop = 0;

    finish_now();
  end

endmodule
